// File: rtl/ring_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_pkg
// Description : Shared definitions for the ring phase decoder: default
//               parameter values, FSM state encoding and the classification
//               of consecutive ring samples.
// Revision    : 1.0 - initial release
// ============================================================================
package ring_pkg;

    localparam int c_DEF_WIDTH    = 4;
    localparam int c_DEF_LOCK_CNT = 4;
    localparam int c_DEF_REV_W    = 8;
    localparam int c_ERR_CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Relationship between the current sample S and the previous sample P.
    typedef enum logic [1:0] {
        CL_HOLD    = 2'd0,
        CL_ADVANCE = 2'd1,
        CL_ILLEGAL = 2'd2
    } pair_class_t;

endpackage
`default_nettype wire

// File: rtl/onehot_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : onehot_to_bin
// Description : Checks a vector for exactly one set bit and encodes the
//               position of that bit in binary. The index is forced to zero
//               whenever the vector is not one-hot.
// Ports       : i_onehot [WIDTH]         - vector to examine
//               o_valid                  - high when exactly one bit is set
//               o_idx    [clog2(WIDTH)]  - binary position of the set bit
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_to_bin
    import ring_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH
) (
    input  logic [WIDTH-1:0]         i_onehot,
    output logic                     o_valid,
    output logic [$clog2(WIDTH)-1:0] o_idx
);

    localparam int c_IW = $clog2(WIDTH);

    logic            w_seen;
    logic            w_multi;
    logic [c_IW-1:0] w_idx;

    // OR-ing the indices of all set bits gives the right answer for a
    // one-hot input; multi-hot inputs are flagged and their index discarded.
    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_onehot[i]) begin
                if (w_seen) begin
                    w_multi = 1'b1;
                end
                w_seen = 1'b1;
                w_idx  = w_idx | c_IW'(i);
            end
        end
    end

    assign o_valid = w_seen & ~w_multi;
    assign o_idx   = o_valid ? w_idx : '0;

endmodule
`default_nettype wire

// File: rtl/ring_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ring_phase_decoder
// Description : Samples a one-hot ring-counter phase, decodes it to binary
//               and tracks whether the ring rotates legally (hold or advance
//               by one position). Locks after LOCK_CNT legal advances, flags
//               illegal transitions while locked and counts revolutions.
// Ports       : clk                     - clock, rising edge active
//               rst                     - asynchronous active-high reset
//               ring_in     [WIDTH]     - one-hot ring phase from upstream
//               phase       [clog2(W)]  - binary index of sampled phase
//               phase_valid             - sampled phase is exactly one-hot
//               locked                  - ring tracked as rotating legally
//               err                     - one-cycle pulse on illegal step
//                                         while locked
//               err_count   [8]         - saturating count of err pulses
//               rev_count   [REV_W]     - wrapping count of revolutions
//                                         completed while locked
// Revision    : 1.0 - initial release
// ============================================================================
module ring_phase_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH    = c_DEF_WIDTH,
    parameter int LOCK_CNT = c_DEF_LOCK_CNT,
    parameter int REV_W    = c_DEF_REV_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         ring_in,
    output logic [$clog2(WIDTH)-1:0] phase,
    output logic                     phase_valid,
    output logic                     locked,
    output logic                     err,
    output logic [7:0]               err_count,
    output logic [REV_W-1:0]         rev_count
);

    localparam int                c_PW         = $clog2(WIDTH);
    localparam int                c_MW         = $clog2(LOCK_CNT + 1);
    localparam logic [c_MW-1:0]   c_LOCK_MATCH = c_MW'(LOCK_CNT);
    localparam logic [c_ERR_CNT_W-1:0] c_ERR_MAX = '1;

    logic [WIDTH-1:0]       r_sample;
    logic [WIDTH-1:0]       r_prev;
    state_t                 r_state;
    logic [c_MW-1:0]        r_match;
    logic                   r_err;
    logic [c_ERR_CNT_W-1:0] r_err_count;
    logic [REV_W-1:0]       r_rev_count;

    logic                   w_valid;
    logic [c_PW-1:0]        w_idx;
    logic [WIDTH-1:0]       w_prev_rot;
    pair_class_t            w_class;
    logic                   w_wrap;
    state_t                 w_state_nxt;
    logic [c_MW-1:0]        w_match_nxt;
    logic                   w_err_nxt;
    logic                   w_rev_inc;

    // ------------------------------------------------------------------
    // Input sampling: S is the current sample, P the one before it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample <= '0;
            r_prev   <= '0;
        end else begin
            r_sample <= ring_in;
            r_prev   <= r_sample;
        end
    end

    onehot_to_bin #(
        .WIDTH (WIDTH)
    ) u_onehot_to_bin (
        .i_onehot (r_sample),
        .o_valid  (w_valid),
        .o_idx    (w_idx)
    );

    assign phase       = w_idx;
    assign phase_valid = w_valid;

    // ------------------------------------------------------------------
    // Pair classification. Only S needs a one-hot check: rotation keeps
    // the number of set bits, so S == P or S == rotl(P) with a one-hot S
    // implies a one-hot P.
    // ------------------------------------------------------------------
    assign w_prev_rot = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};

    always_comb begin
        w_class = CL_ILLEGAL;
        if (w_valid && (r_sample == r_prev)) begin
            w_class = CL_HOLD;
        end else if (w_valid && (r_sample == w_prev_rot)) begin
            w_class = CL_ADVANCE;
        end
    end

    // An advance that lands on index 0 necessarily came from index WIDTH-1.
    assign w_wrap = (w_class == CL_ADVANCE) && r_sample[0];

    // ------------------------------------------------------------------
    // FSM next-state and actions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match;
        w_err_nxt   = 1'b0;
        w_rev_inc   = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_valid) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_match_nxt = '0;
                end
            end
            ST_ACQUIRE: begin
                case (w_class)
                    CL_ADVANCE: begin
                        w_match_nxt = r_match + c_MW'(1);
                        if (w_match_nxt == c_LOCK_MATCH) begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end
                    CL_HOLD: begin
                        w_match_nxt = r_match;
                    end
                    default: begin
                        w_state_nxt = ST_SEARCH;
                    end
                endcase
            end
            ST_LOCKED: begin
                if (w_class == CL_ILLEGAL) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_SEARCH;
                end else begin
                    w_rev_inc = w_wrap;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_SEARCH;
            r_match     <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_rev_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_match <= w_match_nxt;
            r_err   <= w_err_nxt;
            if (w_err_nxt && (r_err_count != c_ERR_MAX)) begin
                r_err_count <= r_err_count + c_ERR_CNT_W'(1);
            end
            if (w_rev_inc) begin
                r_rev_count <= r_rev_count + REV_W'(1);
            end
        end
    end

    assign locked    = (r_state == ST_LOCKED);
    assign err       = r_err;
    assign err_count = r_err_count;
    assign rev_count = r_rev_count;

endmodule
`default_nettype wire
